// File: rtl/ad9783_pkg.sv
// Shared definitions for the AD9783 SPI configuration master.
// This file holds the FSM encoding, the SPI frame field positions, the command word
// bit positions, and a helper that builds the 16-bit frame.
package ad9783_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CS_SETUP  = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CS_HOLD   = 3'd3,
        ST_RST_PULSE = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam int FRAME_W     = 16;

    // Bit positions inside the SPI frame sent to the DAC.
    localparam int FRM_RW      = 15;
    localparam int FRM_N_HI    = 14;
    localparam int FRM_N_LO    = 13;
    localparam int FRM_ADDR_HI = 12;
    localparam int FRM_ADDR_LO = 8;
    localparam int FRM_DATA_HI = 7;
    localparam int FRM_DATA_LO = 0;

    // Bit positions inside the host command address word.
    localparam int CMD_CHIP    = 8;
    localparam int CMD_HWRST   = 12;
    localparam int CMD_READ    = 15;

    // Single-byte transfer: N1:N0 = 00.
    // A read sends zeros in the data slot.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [15:0] addr,
                                                       input logic [15:0] data);
        logic [FRAME_W-1:0] f;
        f                          = '0;
        f[FRM_RW]                  = addr[CMD_READ];
        f[FRM_N_HI:FRM_N_LO]       = 2'b00;
        f[FRM_ADDR_HI:FRM_ADDR_LO] = addr[4:0];
        f[FRM_DATA_HI:FRM_DATA_LO] = addr[CMD_READ] ? 8'h00 : data[7:0];
        return f;
    endfunction

endpackage

// File: rtl/ad9783_spi_shifter.sv
// SCK divider and 16-bit shift/sample engine.
// - load_in presents the frame MSB on SDO.
// - start_in runs 16 bit periods. Each period is sck low for CLKDIV cycles, then sck high
//   for CLKDIV cycles.
// - SDI is sampled on the rising SCK edge.
// - SDO advances on the falling SCK edge.
// - done_out pulses on the final falling edge.
// - half_tick_out also lets the parent time its chip-select setup and hold windows.
module ad9783_spi_shifter
    import ad9783_pkg::*;
#(
    parameter int CLKDIV = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               load_in,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               start_in,
    input  logic               spi_sdi_in,
    output logic               half_tick_out,
    output logic               done_out,
    output logic               spi_sck_out,
    output logic               spi_sdo_out,
    output logic [7:0]         rx_byte_out
);

    localparam int HALF_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               active_q, active_d;
    logic               sck_q, sck_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;

    logic half_tick;
    logic rise_evt;
    logic fall_evt;
    logic last_fall;

    assign half_tick = (half_cnt_q == HALF_W'(CLKDIV - 1));
    assign rise_evt  = active_q && !sck_q && half_tick;
    assign fall_evt  = active_q &&  sck_q && half_tick;
    assign last_fall = fall_evt && (bit_cnt_q == 4'd15);

    // Next-state logic for the divider, the bit counter and the shift registers.
    always_comb begin
        half_cnt_d = half_tick ? '0 : half_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        active_d   = active_q;
        sck_d      = sck_q;
        tx_d       = tx_q;
        rx_d       = rx_q;

        if (load_in || start_in) begin
            half_cnt_d = '0;
        end

        if (load_in) begin
            tx_d = frame_in;
        end else if (fall_evt) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end

        if (rise_evt) begin
            rx_d  = {rx_q[6:0], spi_sdi_in};
            sck_d = 1'b1;
        end else if (fall_evt) begin
            sck_d = 1'b0;
        end

        if (start_in) begin
            active_d  = 1'b1;
            sck_d     = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (last_fall) begin
            active_d  = 1'b0;
        end else if (fall_evt) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    // Register the engine state. The asynchronous reset returns SCK and SDO to idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            active_q   <= 1'b0;
            sck_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            active_q   <= active_d;
            sck_q      <= sck_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    assign half_tick_out = half_tick;
    assign done_out      = last_fall;
    assign spi_sck_out   = sck_q;
    assign spi_sdo_out   = tx_q[FRAME_W-1];
    assign rx_byte_out   = rx_q;

endmodule

// File: rtl/ad9783_spi_ctrl.sv
// AD9783 configuration master for two DACs.
// - Turns host triggers into single-byte SPI register writes or reads, or into
//   hardware RESET pulses.
// - Only the chip chosen by addr[8] ever sees its chip select low or its RESET pin high.
// - The chip selects and RESET pins are decoded from registered state, so the
//   asynchronous reset idles them immediately.
module ad9783_spi_ctrl
    import ad9783_pkg::*;
#(
    parameter int CLKDIV     = 8,
    parameter int RST_CYCLES = 100
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_trig_in,
    input  logic [15:0] cmd_addr_in,
    input  logic [15:0] cmd_data_in,
    output logic [15:0] cmd_data_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        rst0_out,
    output logic        rst1_out,
    output logic        spi_scs0_out,
    output logic        spi_scs1_out,
    output logic        spi_sck_out,
    output logic        spi_sdo_out,
    input  logic        spi_sdi_in
);

    localparam int RST_W = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic             chip_q, chip_d;
    logic             read_q, read_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]       data_q, data_d;

    logic       accept;
    logic       shift_load;
    logic       shift_start;
    logic       half_tick;
    logic       shift_done;
    logic [7:0] rx_byte;
    logic       frame_active;

    assign accept     = (state_q == ST_IDLE) && cmd_trig_in;
    assign shift_load = accept && !cmd_addr_in[CMD_HWRST];

    ad9783_spi_shifter #(
        .CLKDIV (CLKDIV)
    ) u_shifter (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_in       (shift_load),
        .frame_in      (build_frame(cmd_addr_in, cmd_data_in)),
        .start_in      (shift_start),
        .spi_sdi_in    (spi_sdi_in),
        .half_tick_out (half_tick),
        .done_out      (shift_done),
        .spi_sck_out   (spi_sck_out),
        .spi_sdo_out   (spi_sdo_out),
        .rx_byte_out   (rx_byte)
    );

    // Command sequencing.
    // - The read byte is captured while leaving CS_HOLD, so it is already visible in the
    //   DONE cycle.
    always_comb begin
        state_d     = state_q;
        chip_d      = chip_q;
        read_d      = read_q;
        rst_cnt_d   = rst_cnt_q;
        data_d      = data_q;
        shift_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_trig_in) begin
                    chip_d    = cmd_addr_in[CMD_CHIP];
                    read_d    = cmd_addr_in[CMD_READ];
                    rst_cnt_d = '0;
                    state_d   = cmd_addr_in[CMD_HWRST] ? ST_RST_PULSE : ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (half_tick) begin
                    shift_start = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (half_tick) begin
                    if (read_q) begin
                        data_d = rx_byte;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_RST_PULSE: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. An asynchronous reset drops any command in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            chip_q    <= 1'b0;
            read_q    <= 1'b0;
            rst_cnt_q <= '0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            chip_q    <= chip_d;
            read_q    <= read_d;
            rst_cnt_q <= rst_cnt_d;
            data_q    <= data_d;
        end
    end

    assign frame_active = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                          (state_q == ST_CS_HOLD);

    assign spi_scs0_out = !(frame_active && !chip_q);
    assign spi_scs1_out = !(frame_active &&  chip_q);
    assign rst0_out     = (state_q == ST_RST_PULSE) && !chip_q;
    assign rst1_out     = (state_q == ST_RST_PULSE) &&  chip_q;
    assign busy_out     = (state_q != ST_IDLE);
    assign done_out     = (state_q == ST_DONE);
    assign cmd_data_out = {8'h00, data_q};

endmodule
